mem_bus_arbiter: RTL and testbench



---
 rtl/mem_bus_arbiter_pkg.sv | 19 +
 rtl/mem_bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the IF/MEM memory bus arbiter: state encodings, grant
// identifiers and default bus widths.
package mem_bus_arbiter_pkg;

  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StIAddr = 3'd1,
    StIData = 3'd2,
    StDAddr = 3'd3,
    StDData = 3'd4
  } state_e;

  localparam logic GrantInst = 1'b0;
  localparam logic GrantData = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Single-owner SRAM-style bus arbiter between instruction fetch and data access.
// One transaction at a time: grant in idle, address phase, data phase.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrW,
  parameter int unsigned DATA_W = DataW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  inst_req,
  input  logic [ADDR_W-1:0]     inst_addr,
  output logic                  inst_ack,
  output logic                  inst_rvalid,
  output logic [DATA_W-1:0]     inst_rdata,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [DATA_W/8-1:0]   data_wstrb,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [DATA_W-1:0]     data_wdata,
  output logic                  data_ack,
  output logic                  data_done,
  output logic [DATA_W-1:0]     data_rdata,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [DATA_W/8-1:0]   bus_wstrb,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic                  bus_addr_ok,
  input  logic                  bus_data_ok,
  input  logic [DATA_W-1:0]     bus_rdata,
  output logic [1:0]            stall_o
);

  state_e                state_q;
  logic                  cancel_q;
  logic                  last_grant_q;
  logic                  lat_we_q;
  logic [DATA_W/8-1:0]   lat_wstrb_q;
  logic [ADDR_W-1:0]     lat_addr_q;
  logic [DATA_W-1:0]     lat_wdata_q;
  logic [DATA_W-1:0]     inst_rdata_q;
  logic [DATA_W-1:0]     data_rdata_q;
  logic                  inst_rvalid_q;
  logic                  data_done_q;

  logic idle;
  logic inst_ok;
  logic grant_data;
  logic grant_inst;
  logic inst_busy;
  logic data_busy;
  logic pulse;

  always_comb begin
    idle       = (state_q == StIdle);
    // A flush in idle only blocks fetch grants for that cycle.
    inst_ok    = inst_req & ~flush;
    grant_data = idle & data_req & (~inst_ok | (last_grant_q == GrantInst));
    grant_inst = idle & inst_ok & ~grant_data;
    inst_busy  = (state_q == StIAddr) | (state_q == StIData);
    data_busy  = (state_q == StDAddr) | (state_q == StDData);
    pulse      = inst_rvalid_q | data_done_q;
  end

  assign inst_ack    = grant_inst;
  assign data_ack    = grant_data;
  assign bus_req     = (state_q == StIAddr) | (state_q == StDAddr);
  assign bus_we      = lat_we_q;
  assign bus_wstrb   = lat_wstrb_q;
  assign bus_addr    = lat_addr_q;
  assign bus_wdata   = lat_wdata_q;
  assign inst_rvalid = inst_rvalid_q;
  assign inst_rdata  = inst_rdata_q;
  assign data_done   = data_done_q;
  assign data_rdata  = data_rdata_q;

  // A cancelled fetch no longer holds the front end; the pipeline may redirect.
  assign stall_o = pulse ? 2'b00 :
                   {(data_req & ~grant_data) | data_busy,
                    (inst_req & ~grant_inst) | (inst_busy & ~cancel_q)};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cancel_q      <= 1'b0;
      last_grant_q  <= GrantInst;
      lat_we_q      <= 1'b0;
      lat_wstrb_q   <= '0;
      lat_addr_q    <= '0;
      lat_wdata_q   <= '0;
      inst_rdata_q  <= '0;
      data_rdata_q  <= '0;
      inst_rvalid_q <= 1'b0;
      data_done_q   <= 1'b0;
    end else begin
      inst_rvalid_q <= 1'b0;
      data_done_q   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (grant_data) begin
            state_q      <= StDAddr;
            last_grant_q <= GrantData;
            lat_we_q     <= data_we;
            lat_wstrb_q  <= data_wstrb;
            lat_addr_q   <= data_addr;
            lat_wdata_q  <= data_wdata;
          end else if (grant_inst) begin
            state_q      <= StIAddr;
            last_grant_q <= GrantInst;
            lat_we_q     <= 1'b0;
            lat_wstrb_q  <= '0;
            lat_addr_q   <= inst_addr;
            lat_wdata_q  <= '0;
          end
        end
        StIAddr: begin
          if (flush) cancel_q <= 1'b1;
          if (bus_addr_ok) state_q <= StIData;
        end
        StIData: begin
          if (bus_data_ok) begin
            inst_rdata_q  <= bus_rdata;
            inst_rvalid_q <= ~cancel_q & ~flush;
            cancel_q      <= 1'b0;
            state_q       <= StIdle;
          end else if (flush) begin
            cancel_q <= 1'b1;
          end
        end
        StDAddr: begin
          if (bus_addr_ok) state_q <= StDData;
        end
        StDData: begin
          if (bus_data_ok) begin
            data_rdata_q <= bus_rdata;
            data_done_q  <= 1'b1;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_ack;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [3:0]  data_wstrb = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic        data_ack;
  logic        data_done;
  logic [31:0] data_rdata;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok = 1'b0;
  logic        bus_data_ok = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic [1:0]  stall_o;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_we(data_we), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_ack(data_ack),
    .data_done(data_done), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata), .stall_o(stall_o)
  );

  // Reference model: owner of the bus (0 none, 1 fetch, 2 data) and its phase.
  int          m_own = 0;
  bit          m_aph = 1'b0;
  bit          m_cancel = 1'b0;
  bit          m_last = 1'b0;
  logic        m_we = 1'b0;
  logic [3:0]  m_wstrb = '0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_irdata = '0;
  logic [31:0] m_drdata = '0;
  bit          m_rvalid = 1'b0;
  bit          m_done = 1'b0;
  logic        e_iack, e_dack, e_breq;
  logic [1:0]  e_stall;

  task automatic model_comb();
    bit idle, iok, pulse, ist, dst;
    idle   = (m_own == 0);
    iok    = inst_req && !flush;
    e_dack = idle && data_req && (!iok || m_last == 1'b0);
    e_iack = idle && iok && !e_dack;
    e_breq = (m_own != 0) && m_aph;
    pulse  = m_rvalid || m_done;
    ist    = (inst_req && !e_iack) || (m_own == 1 && !m_cancel);
    dst    = (data_req && !e_dack) || (m_own == 2);
    e_stall = pulse ? 2'b00 : {dst, ist};
  endtask

  task automatic model_update();
    model_comb();
    if (!rst_n) begin
      m_own = 0; m_aph = 0; m_cancel = 0; m_last = 0; m_we = 0; m_wstrb = '0;
      m_addr = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0; m_rvalid = 0; m_done = 0;
    end else begin
      m_rvalid = 0;
      m_done   = 0;
      if (m_own == 0) begin
        if (e_dack) begin
          m_own = 2; m_aph = 1; m_last = 1;
          m_we = data_we; m_wstrb = data_wstrb; m_addr = data_addr; m_wdata = data_wdata;
        end else if (e_iack) begin
          m_own = 1; m_aph = 1; m_last = 0;
          m_we = 0; m_wstrb = '0; m_addr = inst_addr; m_wdata = '0;
        end
      end else if (m_aph) begin
        if (m_own == 1 && flush) m_cancel = 1;
        if (bus_addr_ok) m_aph = 0;
      end else if (bus_data_ok) begin
        if (m_own == 1) begin
          m_irdata = bus_rdata;
          m_rvalid = !m_cancel && !flush;
        end else begin
          m_drdata = bus_rdata;
          m_done   = 1;
        end
        m_own = 0;
        m_cancel = 0;
      end else if (m_own == 1 && flush) begin
        m_cancel = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({bus_req, inst_ack, data_ack} !== 3'b000) begin
      n_err++; $display("FAIL reset_req_ack: got %b expected 000", {bus_req, inst_ack, data_ack});
    end
    n_chk++;
    if ({inst_rvalid, data_done} !== 2'b00) begin
      n_err++; $display("FAIL reset_pulses: got %b expected 00", {inst_rvalid, data_done});
    end
    n_chk++;
    if ({inst_rdata, data_rdata} !== 64'h0) begin
      n_err++; $display("FAIL reset_rdata: got %h expected 0", {inst_rdata, data_rdata});
    end
    n_chk++;
    if ({bus_we, bus_wstrb, bus_addr, bus_wdata} !== 69'h0) begin
      n_err++; $display("FAIL reset_bus_fields: got %h expected 0",
                        {bus_we, bus_wstrb, bus_addr, bus_wdata});
    end
    n_chk++;
    if (stall_o !== 2'b00) begin
      n_err++; $display("FAIL reset_stall: got %b expected 00", stall_o);
    end
    tick();
  endtask

  task automatic test_lone_fetch();
    inst_req = 1'b1; inst_addr = 32'h1C00_0000;
    @(negedge clk);
    n_chk++;
    if ({inst_ack, bus_req, stall_o} !== 4'b1000) begin
      n_err++; $display("FAIL fetch_c0: got %b expected 1000", {inst_ack, bus_req, stall_o});
    end
    tick();
    inst_req = 1'b0; bus_addr_ok = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({bus_req, bus_we, bus_wstrb, bus_addr} !== {6'b100000, 32'h1C00_0000}) begin
      n_err++; $display("FAIL fetch_c1_bus: got %h expected %h",
                        {bus_req, bus_we, bus_wstrb, bus_addr}, {6'b100000, 32'h1C00_0000});
    end
    n_chk++;
    if (stall_o !== 2'b01) begin
      n_err++; $display("FAIL fetch_c1_stall: got %b expected 01", stall_o);
    end
    tick();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0280_0C04;
    @(negedge clk);
    n_chk++;
    if ({bus_req, inst_rvalid} !== 2'b00) begin
      n_err++; $display("FAIL fetch_c2: got %b expected 00", {bus_req, inst_rvalid});
    end
    tick();
    bus_data_ok = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({inst_rvalid, inst_rdata, stall_o[0]} !== {1'b1, 32'h0280_0C04, 1'b0}) begin
      n_err++; $display("FAIL fetch_c3: got %h expected %h",
                        {inst_rvalid, inst_rdata, stall_o[0]}, {1'b1, 32'h0280_0C04, 1'b0});
    end
    tick();
    @(negedge clk);
    n_chk++;
    if (inst_rvalid !== 1'b0) begin
      n_err++; $display("FAIL fetch_c4_pulse: got %b expected 0", inst_rvalid);
    end
    tick();
  endtask

  task automatic test_alternation();
    string seq = "";
    int n_done = 0;
    int n_rv = 0;
    inst_req = 1'b1; inst_addr = 32'h1C00_0040;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0000_0100;
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hA5A5_0001;
    for (int c = 0; c < 40 && seq.len() < 6; c++) begin
      @(negedge clk);
      if (data_ack && inst_ack) begin
        n_chk++; n_err++; $display("FAIL alt_double_ack: got 11 expected one-hot");
      end
      if (data_ack) seq = {seq, "D"};
      else if (inst_ack) seq = {seq, "I"};
      if (data_done) n_done++;
      if (inst_rvalid) n_rv++;
      tick();
    end
    inst_req = 1'b0; data_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (data_done) n_done++;
      if (inst_rvalid) n_rv++;
      tick();
    end
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    n_chk++;
    if (seq != "DIDIDI") begin
      n_err++; $display("FAIL alt_sequence: got %s expected DIDIDI", seq);
    end
    n_chk++;
    if (n_done != 3 || n_rv != 3) begin
      n_err++; $display("FAIL alt_completions: got done=%0d rvalid=%0d expected 3 and 3",
                        n_done, n_rv);
    end
  endtask

  task automatic test_store();
    data_req = 1'b1; data_we = 1'b1; data_wstrb = 4'b0011;
    data_addr = 32'h0000_0200; data_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_chk++;
    if (data_ack !== 1'b1) begin
      n_err++; $display("FAIL store_ack: got %b expected 1", data_ack);
    end
    tick();
    data_req = 1'b0; data_we = 1'b0; data_wstrb = 4'hF;
    data_addr = 32'hFFFF_FFF0; data_wdata = 32'h0;
    for (int c = 1; c <= 4; c++) begin
      bus_addr_ok = (c == 4);
      @(negedge clk);
      n_chk++;
      if ({bus_req, bus_we, bus_wstrb, bus_addr, bus_wdata, stall_o[1]} !==
          {2'b11, 4'b0011, 32'h0000_0200, 32'hDEAD_BEEF, 1'b1}) begin
        n_err++; $display("FAIL store_hold_c%0d: got %h expected %h", c,
                          {bus_req, bus_we, bus_wstrb, bus_addr, bus_wdata, stall_o[1]},
                          {2'b11, 4'b0011, 32'h0000_0200, 32'hDEAD_BEEF, 1'b1});
      end
      tick();
    end
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0;
    @(negedge clk);
    n_chk++;
    if ({bus_req, data_done, stall_o[1]} !== 3'b001) begin
      n_err++; $display("FAIL store_data_phase: got %b expected 001",
                        {bus_req, data_done, stall_o[1]});
    end
    tick();
    bus_data_ok = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({data_done, stall_o[1]} !== 2'b10) begin
      n_err++; $display("FAIL store_done: got %b expected 10", {data_done, stall_o[1]});
    end
    tick();
  endtask

  task automatic test_flush_fetch();
    inst_req = 1'b1; inst_addr = 32'h1C00_0100;
    @(negedge clk);
    n_chk++;
    if (inst_ack !== 1'b1) begin
      n_err++; $display("FAIL flushf_ack: got %b expected 1", inst_ack);
    end
    tick();
    inst_req = 1'b0; bus_addr_ok = 1'b1;
    @(negedge clk); tick();
    bus_addr_ok = 1'b0; flush = 1'b1;
    @(negedge clk); tick();
    flush = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h1111_2222;
    @(negedge clk);
    n_chk++;
    if (stall_o[0] !== 1'b0) begin
      n_err++; $display("FAIL flushf_stall: got %b expected 0", stall_o[0]);
    end
    tick();
    bus_data_ok = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({inst_rvalid, inst_rdata} !== {1'b0, 32'h1111_2222}) begin
      n_err++; $display("FAIL flushf_suppress: got %h expected %h",
                        {inst_rvalid, inst_rdata}, {1'b0, 32'h1111_2222});
    end
    tick();
    inst_req = 1'b1; inst_addr = 32'h1C00_0104;
    @(negedge clk);
    n_chk++;
    if (inst_ack !== 1'b1) begin
      n_err++; $display("FAIL flushf_next_ack: got %b expected 1", inst_ack);
    end
    tick();
    inst_req = 1'b0; bus_addr_ok = 1'b1;
    @(negedge clk); tick();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h3333_4444;
    @(negedge clk); tick();
    bus_data_ok = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({inst_rvalid, inst_rdata} !== {1'b1, 32'h3333_4444}) begin
      n_err++; $display("FAIL flushf_next_rvalid: got %h expected %h",
                        {inst_rvalid, inst_rdata}, {1'b1, 32'h3333_4444});
    end
    tick();
  endtask

  task automatic test_flush_data();
    data_req = 1'b1; data_we = 1'b1; data_wstrb = 4'hF;
    data_addr = 32'h0000_0300; data_wdata = 32'hCAFE_F00D;
    @(negedge clk); tick();
    data_req = 1'b0; flush = 1'b1;
    @(negedge clk);
    n_chk++;
    if (bus_req !== 1'b1) begin
      n_err++; $display("FAIL flushd_busreq: got %b expected 1", bus_req);
    end
    tick();
    flush = 1'b0; bus_addr_ok = 1'b1;
    @(negedge clk); tick();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; flush = 1'b1;
    @(negedge clk); tick();
    bus_data_ok = 1'b0; flush = 1'b0;
    @(negedge clk);
    n_chk++;
    if (data_done !== 1'b1) begin
      n_err++; $display("FAIL flushd_done: got %b expected 1", data_done);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    inst_req = 1'b1; inst_addr = 32'h1C00_0200;
    @(negedge clk); tick();
    inst_req = 1'b0; bus_addr_ok = 1'b1;
    @(negedge clk); tick();
    bus_addr_ok = 1'b0; rst_n = 1'b0;
    @(negedge clk); tick();
    rst_n = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h5555_6666;
    @(negedge clk);
    n_chk++;
    if ({bus_req, inst_rvalid, stall_o, inst_rdata, bus_addr, data_rdata} !== 100'h0) begin
      n_err++; $display("FAIL rstmid_outputs: got %h expected 0",
                        {bus_req, inst_rvalid, stall_o, inst_rdata, bus_addr, data_rdata});
    end
    tick();
    bus_data_ok = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({inst_rvalid, inst_rdata} !== 33'h0) begin
      n_err++; $display("FAIL rstmid_stale: got %h expected 0", {inst_rvalid, inst_rdata});
    end
    tick();
    inst_req = 1'b1; inst_addr = 32'h1C00_0300;
    @(negedge clk);
    n_chk++;
    if (inst_ack !== 1'b1) begin
      n_err++; $display("FAIL rstmid_new_ack: got %b expected 1", inst_ack);
    end
    tick();
    inst_req = 1'b0; bus_addr_ok = 1'b1;
    @(negedge clk); tick();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h7777_8888;
    @(negedge clk); tick();
    bus_data_ok = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({inst_rvalid, inst_rdata} !== {1'b1, 32'h7777_8888}) begin
      n_err++; $display("FAIL rstmid_new_rvalid: got %h expected %h",
                        {inst_rvalid, inst_rdata}, {1'b1, 32'h7777_8888});
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst_n       = ($urandom_range(0, 99) != 0);
      inst_req    = 1'($urandom_range(0, 1));
      data_req    = 1'($urandom_range(0, 1));
      flush       = ($urandom_range(0, 7) == 0);
      data_we     = 1'($urandom_range(0, 1));
      data_wstrb  = 4'($urandom());
      inst_addr   = $urandom();
      data_addr   = $urandom();
      data_wdata  = $urandom();
      bus_addr_ok = 1'($urandom_range(0, 1));
      bus_data_ok = 1'($urandom_range(0, 1));
      bus_rdata   = $urandom();
      @(negedge clk);
      model_comb();
      n_chk++;
      if ({inst_ack, data_ack, bus_req, stall_o} !== {e_iack, e_dack, e_breq, e_stall}) begin
        n_err++; $display("FAIL rand_handshake cyc %0d: got %b expected %b", c,
                          {inst_ack, data_ack, bus_req, stall_o},
                          {e_iack, e_dack, e_breq, e_stall});
      end
      n_chk++;
      if ({bus_we, bus_wstrb, bus_addr, bus_wdata} !== {m_we, m_wstrb, m_addr, m_wdata}) begin
        n_err++; $display("FAIL rand_bus_fields cyc %0d: got %h expected %h", c,
                          {bus_we, bus_wstrb, bus_addr, bus_wdata},
                          {m_we, m_wstrb, m_addr, m_wdata});
      end
      n_chk++;
      if ({inst_rvalid, inst_rdata, data_done, data_rdata} !==
          {m_rvalid, m_irdata, m_done, m_drdata}) begin
        n_err++; $display("FAIL rand_response cyc %0d: got %h expected %h", c,
                          {inst_rvalid, inst_rdata, data_done, data_rdata},
                          {m_rvalid, m_irdata, m_done, m_drdata});
      end
      tick();
    end
    rst_n = 1'b1; inst_req = 1'b0; data_req = 1'b0; flush = 1'b0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_alternation();
    test_store();
    test_flush_fetch();
    test_flush_data();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
